// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-master (inst/data) to one SRAM-like slave request arbiter
// Data wins by default; inst is forced through after STARVE_LIMIT data grants while it waits.
module sram_req_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  output logic        protocol_err
);

  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic [2:0]  starve_cnt, starve_nxt;
  logic        gnt, sel, fwd, accept, err_evt;

  assign inst_rdata = s_rdata;
  assign data_rdata = s_rdata;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      owner        <= 1'b0;
      starve_cnt   <= 3'd0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      starve_cnt   <= starve_nxt;
      protocol_err <= protocol_err | err_evt;
    end
  end

  always_comb begin
    gnt = data_req;
    if (inst_req && ({29'd0, starve_cnt} >= STARVE_LIMIT)) gnt = 1'b0;
    sel = (state == IDLE) ? gnt : owner;
    // Outputs are gated by aresetn so nothing is forwarded while reset is held.
    fwd = aresetn && ((state == IDLE) || (state == HOLD));

    s_req = 1'b0;
    if (fwd) begin
      if (state == IDLE) s_req = inst_req | data_req;
      else               s_req = owner ? data_req : inst_req;
    end
    s_wr    = sel ? data_wr    : inst_wr;
    s_size  = sel ? data_size  : inst_size;
    s_addr  = sel ? data_addr  : inst_addr;
    s_wdata = sel ? data_wdata : inst_wdata;

    accept       = s_req && s_addr_ok;
    inst_addr_ok = accept && !sel;
    data_addr_ok = accept && sel;
    inst_data_ok = aresetn && (state == RESP) && s_data_ok && !owner;
    data_data_ok = aresetn && (state == RESP) && s_data_ok && owner;
    err_evt      = (s_data_ok && (state != RESP)) || (s_addr_ok && !s_req);

    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE: if (s_req) begin
        owner_nxt = gnt;
        state_nxt = s_addr_ok ? RESP : HOLD;
      end
      HOLD: begin
        if (!s_req)        state_nxt = IDLE;
        else if (s_addr_ok) state_nxt = RESP;
      end
      RESP: if (s_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    starve_nxt = starve_cnt;
    if (!inst_req)                           starve_nxt = 3'd0;
    else if (accept && !sel)                 starve_nxt = 3'd0;
    else if (accept && sel && starve_cnt != 3'd7) starve_nxt = starve_cnt + 3'd1;
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - directed scoreboard bench for sram_req_arbiter
module tb_sram_req_arbiter;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, s_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata, data_addr, data_wdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        s_req, s_wr, s_addr_ok, s_data_ok, protocol_err;
  logic [31:0] s_addr, s_wdata, s_rdata;

  typedef struct packed {
    logic        who;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  sram_req_arbiter #(.STARVE_LIMIT(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
    .protocol_err(protocol_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drive one response cycle and pop the scoreboard entry it must complete.
  task automatic resp_phase(input logic [31:0] rd);
    exp_t e;
    s_data_ok = 1'b1;
    s_rdata   = rd;
    #1;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("data_ok_owner", {30'd0, data_data_ok, inst_data_ok}, e.who ? 32'd2 : 32'd1);
      check("rdata", e.who ? data_rdata : inst_rdata, e.rd);
    end
    tick();
    s_data_ok = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1000; inst_wdata = 32'h0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h2000; data_wdata = 32'h0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
    #12;
    check("rst_s_req", {31'd0, s_req}, 32'd0);
    s_addr_ok = 1'b1;
    #1;
    check("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    check("rst_protocol_err", {31'd0, protocol_err}, 32'd0);
    s_addr_ok = 1'b0;
    tick();
    aresetn = 1'b1;

    // Both request, slave accepts immediately: data wins.
    s_addr_ok = 1'b1;
    #1;
    check("both_s_addr", s_addr, 32'h2000);
    check("both_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
    sb.push_back('{who: 1'b1, rd: 32'hDEADBEEF});
    tick();
    s_addr_ok = 1'b0; data_req = 1'b0; inst_req = 1'b0;
    #1;
    check("resp_s_req", {31'd0, s_req}, 32'd0);
    tick();
    resp_phase(32'hDEADBEEF);

    // Data write forwarding.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wdata = 32'h12345678; data_addr = 32'h3000;
    s_addr_ok = 1'b1;
    #1;
    check("wr_s_wr", {31'd0, s_wr}, 32'd1);
    check("wr_s_size", {30'd0, s_size}, 32'd2);
    check("wr_s_wdata", s_wdata, 32'h12345678);
    check("wr_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
    sb.push_back('{who: 1'b1, rd: 32'h0});
    tick();
    data_req = 1'b0; data_wr = 1'b0; s_addr_ok = 1'b0;
    resp_phase(32'h0);

    // Inst held in HOLD; data arrives later and must wait.
    inst_req = 1'b1; inst_addr = 32'h1000; data_addr = 32'h2000;
    #1;
    check("hold0_s_addr", s_addr, 32'h1000);
    tick();
    data_req = 1'b1;
    #1;
    check("hold1_s_addr", s_addr, 32'h1000);
    tick();
    check("hold2_s_addr", s_addr, 32'h1000);
    tick();
    s_addr_ok = 1'b1;
    #1;
    check("hold_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd1);
    check("hold3_s_addr", s_addr, 32'h1000);
    sb.push_back('{who: 1'b0, rd: 32'hAAAA0001});
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b0;
    #1;
    check("hold_resp_s_req", {31'd0, s_req}, 32'd0);
    resp_phase(32'hAAAA0001);
    s_addr_ok = 1'b1;
    #1;
    check("after_inst_s_addr", s_addr, 32'h2000);
    check("after_inst_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
    sb.push_back('{who: 1'b1, rd: 32'hBBBB0002});
    tick();
    data_req = 1'b0; s_addr_ok = 1'b0;
    resp_phase(32'hBBBB0002);

    // Starvation: both held high, expect data x4 then inst, repeating.
    inst_req = 1'b1; data_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic exp_who;
      exp_who = ((i % 5) == 4) ? 1'b0 : 1'b1;
      sb.push_back('{who: exp_who, rd: 32'hC000_0000 + i});
      s_addr_ok = 1'b1;
      #1;
      check($sformatf("starve%0d_s_addr", i), s_addr, exp_who ? 32'h2000 : 32'h1000);
      tick();
      s_addr_ok = 1'b0;
      resp_phase(32'hC000_0000 + i);
    end
    inst_req = 1'b0; data_req = 1'b0;
    tick();

    // Stray s_data_ok in IDLE.
    s_data_ok = 1'b1;
    #1;
    check("stray_data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
    tick();
    s_data_ok = 1'b0;
    #1;
    check("perr_set", {31'd0, protocol_err}, 32'd1);
    tick();
    tick();
    check("perr_sticky", {31'd0, protocol_err}, 32'd1);

    // Asynchronous reset while RESP.
    inst_req = 1'b1;
    s_addr_ok = 1'b1;
    tick();
    s_addr_ok = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    check("areset_perr", {31'd0, protocol_err}, 32'd0);
    check("areset_s_req", {31'd0, s_req}, 32'd0);
    s_data_ok = 1'b1;
    #1;
    check("areset_data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
    s_data_ok = 1'b0; inst_req = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    s_data_ok = 1'b1;
    tick();
    s_data_ok = 1'b0;
    check("late_data_ok_perr", {31'd0, protocol_err}, 32'd1);
    inst_req = 1'b1; inst_addr = 32'h4000;
    s_addr_ok = 1'b1;
    #1;
    check("post_rst_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd1);
    check("post_rst_s_addr", s_addr, 32'h4000);
    sb.push_back('{who: 1'b0, rd: 32'h5555AAAA});
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b0;
    resp_phase(32'h5555AAAA);

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
